// File: rtl/vga_timing_pkg.sv
// Shared timing constants, counter widths and decoder state encoding for the
// VGA sync decoder and its helpers.
package vga_timing_pkg;

  // Nominal 640x480@60 timing in pixel clocks / lines
  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_TOTAL_DEF     = 525;
  localparam int LOCK_FRAMES_DEF = 2;

  // Counter and datapath widths
  localparam int CNT_W   = 11;
  localparam int COORD_W = 10;
  localparam int PIX_W   = 8;
  localparam int SUM_W   = 16;
  localparam int GOOD_W  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } dec_state_t;

  // Saturating increment used by every timing counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 11'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers one sync/blank input (stage 0) and flags rising/falling edges
// between the stage-0 value and its previous value.
module sync_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;
  logic r_q_d;

  // Stage-0 capture plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q   <= i_d;
      r_q_d <= r_q;
    end
  end

  assign o_q    = r_q;
  assign o_rise = r_q & ~r_q_d;
  assign o_fall = ~r_q & r_q_d;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers x/y coordinates from hsync/vsync/blank_n,
// verifies every frame against nominal timing and declares lock after
// LOCK_FRAMES consecutive good frames.
// Optional per-frame pixel checksum enabled by defining VGA_DEC_CHECKSUM_EN;
// without it frame_sum is tied to zero.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [7:0]  pixel_in,
  output logic [7:0]  pixel_out,
  output logic        pixel_valid,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        sof,
  output logic        locked,
  output logic        frame_err,
  output logic [15:0] frame_sum
);

  localparam logic [CNT_W-1:0]   H_TOTAL_C  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0]   H_ACTIVE_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]   V_TOTAL_C  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0]   V_ACTIVE_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]   Y_LAST_C   = CNT_W'(V_ACTIVE - 1);
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(V_ACTIVE - 1);
  localparam logic [GOOD_W-1:0]  LOCK_C     = GOOD_W'(LOCK_FRAMES);

  // Stage 0: sync/blank registers and edge pulses
  logic w_hs_q, w_hs_rise, w_hs_fall;
  logic w_vs_q, w_vs_rise, w_vs_fall;
  logic w_bn_q, w_bn_rise, w_bn_fall;
  logic [PIX_W-1:0] r_pix0;

  sync_edge_det u_hs_det (
    .clk    (clk),
    .reset  (reset),
    .i_d    (hsync),
    .o_q    (w_hs_q),
    .o_rise (w_hs_rise),
    .o_fall (w_hs_fall)
  );

  sync_edge_det u_vs_det (
    .clk    (clk),
    .reset  (reset),
    .i_d    (vsync),
    .o_q    (w_vs_q),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  sync_edge_det u_bn_det (
    .clk    (clk),
    .reset  (reset),
    .i_d    (blank_n),
    .o_q    (w_bn_q),
    .o_rise (w_bn_rise),
    .o_fall (w_bn_fall)
  );

  // Sync levels and rising edges are not needed; only falls and blank level matter
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, w_hs_q, w_hs_rise, w_vs_q, w_vs_rise};

  // Stage-0 pixel register, aligned with the sync registers above
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix0 <= 8'd0;
    end else begin
      r_pix0 <= pixel_in;
    end
  end

  // Timing counters and sticky line error
  logic [CNT_W-1:0]   r_clk_cnt, r_line_cnt, r_act_lines;
  logic [COORD_W-1:0] r_x_cnt;
  logic               r_h_bad;

  logic [CNT_W-1:0]   w_clk_cnt_nxt, w_line_nxt, w_act_nxt;
  logic [COORD_W-1:0] w_x_nxt, w_y_nxt;
  logic               w_h_bad_nxt, w_line_err, w_frame_ok;

  // Next values of line/pixel/frame counters; events of a vsync-fall cycle
  // belong to the new frame
  always_comb begin
    w_line_err    = 1'b0;
    w_clk_cnt_nxt = r_clk_cnt;
    w_x_nxt       = r_x_cnt;
    w_line_nxt    = r_line_cnt;
    w_act_nxt     = r_act_lines;
    w_h_bad_nxt   = r_h_bad;

    if (w_hs_fall) begin
      if (r_clk_cnt != H_TOTAL_C) begin
        w_line_err = 1'b1;
      end else begin
        w_line_err = w_line_err;
      end
      w_clk_cnt_nxt = 11'd1;
    end else begin
      w_clk_cnt_nxt = sat_inc(r_clk_cnt);
    end

    if (w_bn_rise) begin
      w_x_nxt = 10'd0;
    end else if (w_bn_q) begin
      if (r_x_cnt >= X_MAX) begin
        w_x_nxt    = X_MAX;
        w_line_err = 1'b1;
      end else begin
        w_x_nxt = r_x_cnt + 10'd1;
      end
    end else begin
      w_x_nxt = r_x_cnt;
    end

    // r_x_cnt holds the index of the last active pixel, so count is +1
    if (w_bn_fall && (({1'b0, r_x_cnt} + 11'd1) != H_ACTIVE_C)) begin
      w_line_err = 1'b1;
    end else begin
      w_line_err = w_line_err;
    end

    if (w_vs_fall) begin
      w_line_nxt  = w_hs_fall ? 11'd1 : 11'd0;
      w_act_nxt   = w_bn_fall ? 11'd1 : 11'd0;
      w_h_bad_nxt = w_line_err;
    end else begin
      w_line_nxt  = w_hs_fall ? sat_inc(r_line_cnt) : r_line_cnt;
      w_act_nxt   = w_bn_fall ? sat_inc(r_act_lines) : r_act_lines;
      w_h_bad_nxt = r_h_bad | w_line_err;
    end

    if (r_act_lines >= Y_LAST_C) begin
      w_y_nxt = Y_MAX;
    end else begin
      w_y_nxt = r_act_lines[COORD_W-1:0];
    end

    w_frame_ok = !r_h_bad && (r_line_cnt == V_TOTAL_C) && (r_act_lines == V_ACTIVE_C);
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_cnt   <= 11'd0;
      r_line_cnt  <= 11'd0;
      r_act_lines <= 11'd0;
      r_x_cnt     <= 10'd0;
      r_h_bad     <= 1'b0;
    end else begin
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_line_cnt  <= w_line_nxt;
      r_act_lines <= w_act_nxt;
      r_x_cnt     <= w_x_nxt;
      r_h_bad     <= w_h_bad_nxt;
    end
  end

  // Lock state machine
  dec_state_t        r_state, w_state_nxt;
  logic [GOOD_W-1:0] r_good, w_good_nxt;
  logic              w_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEARCH;
      r_good  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  // Next-state: the first frame after SEARCH is measurement only
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_err       = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_vs_fall) begin
          w_state_nxt = ALIGN;
          w_good_nxt  = 4'd0;
        end else begin
          w_state_nxt = SEARCH;
        end
      end
      ALIGN: begin
        if (w_vs_fall) begin
          if (w_frame_ok) begin
            w_good_nxt = r_good + 4'd1;
            if ((r_good + 4'd1) >= LOCK_C) begin
              w_state_nxt = LOCKED;
            end else begin
              w_state_nxt = ALIGN;
            end
          end else begin
            w_err       = 1'b1;
            w_good_nxt  = 4'd0;
            w_state_nxt = ALIGN;
          end
        end else begin
          w_state_nxt = ALIGN;
        end
      end
      LOCKED: begin
        if (w_vs_fall && !w_frame_ok) begin
          w_err       = 1'b1;
          w_good_nxt  = 4'd0;
          w_state_nxt = SEARCH;
        end else begin
          w_state_nxt = LOCKED;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_good_nxt  = 4'd0;
      end
    endcase
  end

  // Stage 1: all outputs registered; lock follows the post-edge state so
  // locked/pixel_valid fall on the same edge as frame_err
  logic [PIX_W-1:0]   r_pixel_out;
  logic               r_pixel_valid, r_sof, r_locked, r_frame_err;
  logic [COORD_W-1:0] r_x, r_y;
  logic               w_locked_nxt, w_valid_nxt;

  assign w_locked_nxt = (w_state_nxt == LOCKED);
  assign w_valid_nxt  = w_bn_q && w_locked_nxt;

  // Output stage register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel_out   <= 8'd0;
      r_pixel_valid <= 1'b0;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_sof         <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_pixel_out   <= r_pix0;
      r_pixel_valid <= w_valid_nxt;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_sof         <= w_valid_nxt && (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
      r_locked      <= w_locked_nxt;
      r_frame_err   <= w_err;
    end
  end

  assign pixel_out   = r_pixel_out;
  assign pixel_valid = r_pixel_valid;
  assign x           = r_x;
  assign y           = r_y;
  assign sof         = r_sof;
  assign locked      = r_locked;
  assign frame_err   = r_frame_err;

`ifdef VGA_DEC_CHECKSUM_EN
  logic [SUM_W-1:0] r_acc, r_frame_sum, w_acc_total;

  assign w_acc_total = r_acc + (r_pixel_valid ? {8'd0, r_pixel_out} : 16'd0);

  // Modular per-frame accumulator, published and cleared at each vsync fall
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= 16'd0;
      r_frame_sum <= 16'd0;
    end else if (w_vs_fall) begin
      r_acc       <= 16'd0;
      r_frame_sum <= w_acc_total;
    end else begin
      r_acc       <= w_acc_total;
      r_frame_sum <= r_frame_sum;
    end
  end

  assign frame_sum = r_frame_sum;
`else
  assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced raster
// (8x4 active, 12 clocks/line, 6 lines/frame) so full frames stay short.
module tb_vga_sync_decoder;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 4;
  localparam int VT = 6;
  localparam int LF = 2;

  logic        clk = 1'b0;
  logic        reset, hsync, vsync, blank_n;
  logic [7:0]  pixel_in;
  logic [7:0]  pixel_out;
  logic        pixel_valid, sof, locked, frame_err;
  logic [9:0]  x, y;
  logic [15:0] frame_sum;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE    (HA),
    .H_TOTAL     (HT),
    .V_ACTIVE    (VA),
    .V_TOTAL     (VT),
    .LOCK_FRAMES (LF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank_n     (blank_n),
    .pixel_in    (pixel_in),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .x           (x),
    .y           (y),
    .sof         (sof),
    .locked      (locked),
    .frame_err   (frame_err),
    .frame_sum   (frame_sum)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // per-frame monitor state
  int          pv_cnt, sof_cnt, err_cnt, pix_bad, x_max;
  int          first_pv_cyc, bn_rise_cyc;
  logic [9:0]  first_x, first_y;
  logic        first_sof, prev_locked, err_prev_locked, cur_pconst;
  logic [1:0]  err_view;
  logic [47:0] rst_view;
  logic        rst_seen;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one pixel clock: sample outputs at the falling edge, then drive inputs
  task automatic drive_cycle(input logic hs, input logic vs, input logic bn,
                             input logic [7:0] pix, input logic rst);
    @(negedge clk);
    cyc++;
    if (reset) begin
      rst_seen = 1'b1;
      rst_view = {pixel_out, pixel_valid, x, y, sof, locked, frame_err, frame_sum};
    end
    if (pixel_valid) begin
      pv_cnt++;
      if (first_pv_cyc < 0) begin
        first_pv_cyc = cyc;
        first_x      = x;
        first_y      = y;
        first_sof    = sof;
      end
      if (!cur_pconst && (pixel_out != x[7:0])) pix_bad++;
    end
    if (int'(x) > x_max) x_max = int'(x);
    if (sof) sof_cnt++;
    if (frame_err) begin
      err_cnt++;
      err_view        = {locked, pixel_valid};
      err_prev_locked = prev_locked;
    end
    prev_locked = locked;
    hsync    = hs;
    vsync    = vs;
    blank_n  = bn;
    pixel_in = pix;
    reset    = rst;
  endtask

  // one full frame: lines 0..VA-1 active, vsync low for line 4,
  // hsync low at h=9..10; optional short line, long blank line, reset point
  task automatic drive_frame(input int short_line, input int long_line,
                             input int rst_line, input logic pconst);
    int hend, alen;
    logic bn;
    pv_cnt = 0; sof_cnt = 0; err_cnt = 0; pix_bad = 0; x_max = 0;
    first_pv_cyc = -1; rst_seen = 1'b0; cur_pconst = pconst;
    err_view = 2'b11; err_prev_locked = 1'b0;
    bn_rise_cyc = cyc + 1;
    for (int l = 0; l < VT; l++) begin
      hend = (l == short_line) ? HT - 1 : HT;
      alen = (l == long_line) ? HA + 1 : HA;
      for (int h = 0; h < hend; h++) begin
        bn = (l < VA) && (h < alen);
        drive_cycle(!((h == 9) || (h == 10)), !(l == 4), bn,
                    pconst ? 8'd1 : 8'(h), (l == rst_line) && (h == 3));
      end
    end
  endtask

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0; pixel_in = 8'd0;
    prev_locked = 1'b0; rst_seen = 1'b0; rst_view = '1; cur_pconst = 1'b0;
    pv_cnt = 0; sof_cnt = 0; err_cnt = 0; pix_bad = 0; x_max = 0;
    repeat (4) drive_cycle(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    check_val("reset_outputs", 32'(rst_view == 48'd0), 32'd1);
    drive_cycle(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // acquisition: SEARCH -> ALIGN -> good 1 -> LOCKED at 3rd vsync fall
    drive_frame(-1, -1, -1, 1'b0);
    check_val("f1_locked", 32'(locked), 32'd0);
    check_val("f1_err", err_cnt, 32'd0);
    drive_frame(-1, -1, -1, 1'b0);
    check_val("f2_locked", 32'(locked), 32'd0);
    check_val("f2_err", err_cnt, 32'd0);
    drive_frame(-1, -1, -1, 1'b0);
    check_val("lock_3rd_vs", 32'(locked), 32'd1);
    check_val("f3_no_valid", pv_cnt, 32'd0);

    // first fully locked frame
    drive_frame(-1, -1, -1, 1'b0);
    check_val("pv_count", pv_cnt, 32'(HA * VA));
    check_val("sof_count", sof_cnt, 32'd1);
    check_val("pixel_eq_x", pix_bad, 32'd0);
    check_val("latency", first_pv_cyc - bn_rise_cyc, 32'd2);
    check_val("first_x", 32'(first_x), 32'd0);
    check_val("first_y", 32'(first_y), 32'd0);
    check_val("first_sof", 32'(first_sof), 32'd1);
    check_val("x_max", x_max, 32'(HA - 1));
    check_val("f4_err", err_cnt, 32'd0);
    check_val("f4_locked", 32'(locked), 32'd1);
`ifdef VGA_DEC_CHECKSUM_EN
    check_val("f4_sum", 32'(frame_sum), 32'd112);
`else
    check_val("f4_sum", 32'(frame_sum), 32'd0);
`endif

    // short line while locked
    drive_frame(-1 + 2, -1, -1, 1'b0);
    check_val("short_err", err_cnt, 32'd1);
    check_val("short_unlocked", 32'(locked), 32'd0);
    check_val("drop_with_err", 32'(err_view), 32'd0);
    check_val("locked_before_err", 32'(err_prev_locked), 32'd1);
    check_val("short_pv_count", pv_cnt, 32'(HA * VA));
`ifdef VGA_DEC_CHECKSUM_EN
    check_val("f5_sum", 32'(frame_sum), 32'd112);
`else
    check_val("f5_sum", 32'(frame_sum), 32'd0);
`endif
    drive_frame(-1, -1, -1, 1'b0);
    check_val("relock_1", 32'(locked), 32'd0);
    drive_frame(-1, -1, -1, 1'b0);
    check_val("relock_2", 32'(locked), 32'd0);
    drive_frame(-1, -1, -1, 1'b0);
    check_val("relock_3", 32'(locked), 32'd1);

    // reset mid-frame while locked
    drive_frame(-1, -1, 1, 1'b0);
    check_val("midrst_seen", 32'(rst_seen), 32'd1);
    check_val("midrst_outputs", 32'(rst_view == 48'd0), 32'd1);
    check_val("midrst_no_err", err_cnt, 32'd0);
    check_val("midrst_locked", 32'(locked), 32'd0);

    // overlong active line during ALIGN
    drive_frame(-1, 2, -1, 1'b0);
    check_val("long_err", err_cnt, 32'd1);
    check_val("long_x_sat", x_max, 32'(HA - 1));
    check_val("long_locked", 32'(locked), 32'd0);
    drive_frame(-1, -1, -1, 1'b0);
    check_val("lock_delayed", 32'(locked), 32'd0);
    drive_frame(-1, -1, -1, 1'b0);
    check_val("lock_after_delay", 32'(locked), 32'd1);

    // constant pixel frame for checksum
    drive_frame(-1, -1, -1, 1'b1);
    check_val("const_pv_count", pv_cnt, 32'(HA * VA));
`ifdef VGA_DEC_CHECKSUM_EN
    check_val("const_sum", 32'(frame_sum), 32'(HA * VA));
`else
    check_val("const_sum", 32'(frame_sum), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
